mc_main_ctrl: RTL

- Multi-cycle MIPS main control FSM. Decodes the 6-bit opcode held in IR and drives the datapath enables, the mux selects and the 2-bit ALUop consumed by the ALU control decoder.
- Sits between the instruction register and the datapath/ALU-control pair, and sequences IF/ID/EX/MEM/WB over multiple cycles.
- Supports a memory-ready handshake, so memory can take more than one cycle.

---
 rtl/mc_ctrl_pkg.sv | 46 ++++
 rtl/mc_ctrl_if.sv | 37 +++
 rtl/mc_ctrl_outdec.sv | 107 ++++++++++
 rtl/mc_main_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: states, opcodes
// and datapath select codes.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_MADR = 4'd2,
    S_MRD  = 4'd3,
    S_MWB  = 4'd4,
    S_MWR  = 4'd5,
    S_REX  = 4'd6,
    S_RWB  = 4'd7,
    S_BR   = 4'd8,
    S_JMP  = 4'd9,
    S_IEX  = 4'd10,
    S_IWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: IR opcode, ALU flag, memory handshake and all
// control outputs. master = controller side, slave = datapath side.
interface mc_ctrl_if #(parameter int STATE_W = 4);
  logic [5:0]         opcode;
  logic               zero;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_cond;
  logic               branch_ne;
  logic               iord;
  logic               mem_read;
  logic               mem_write;
  logic               ir_write;
  logic               memto_reg;
  logic               reg_dst;
  logic               reg_write;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         alu_op;
  logic [1:0]         pc_source;
  logic [STATE_W-1:0] state;
  logic               illegal_op;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
           memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write,
           memto_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
           state, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// Combinational Moore output decode for the main control FSM; mem_ok is the
// already-qualified memory handshake, rst gates every strobe and write enable.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     st,
  input  logic [5:0] opcode,
  input  logic       mem_ok,
  input  logic       rst,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       memto_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    memto_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_B;
    alu_op        = ALUOP_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    case (st)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ok;
        pc_write  = mem_ok;
      end
      S_ID: begin
        alu_src_b  = SRCB_IMM_SH;
        illegal_op = !op_supported(opcode);
      end
      S_MADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MWB: begin
        reg_write = 1'b1;
        memto_reg = 1'b1;
      end
      S_MWR: begin
        iord      = 1'b1;
        mem_write = mem_ok;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNC;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BR: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        branch_ne     = (opcode == OP_BNE);
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: reg_write = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake.
// Optional MC_CTRL_PERF_CNT_EN adds retired-instruction and cycle counters.
//
// state | meaning
// IF    | fetch, wait for memory, load IR and PC+4
// ID    | decode, branch target into ALUOut
// MADR  | lw/sw address compute
// MRD   | load data read, wait for memory
// MWB   | load writeback from MDR
// MWR   | store write, wait for memory
// REX   | R-type execute
// RWB   | R-type writeback to rd
// BR    | beq/bne compare and conditional PC load
// JMP   | jump
// IEX   | addi execute
// IWB   | addi writeback to rt
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1,
  parameter int STATE_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
  mc_ctrl_if.master   bus
`ifdef MC_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] inst_retired,
  output logic [31:0] cyc_cnt
`endif
);

  state_t cur;
  state_t nxt;
  logic   mem_ok;
  logic   unused_zero;

  // zero is consumed by the datapath PC-load gate, not by the FSM
  assign unused_zero = bus.zero;
  assign mem_ok      = WAIT_MEM ? bus.mem_ready : 1'b1;
  assign bus.state   = STATE_W'(cur);

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IF;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF: nxt = mem_ok ? S_ID : S_IF;
      S_ID: begin
        case (bus.opcode)
          OP_LW, OP_SW:   nxt = S_MADR;
          OP_RTYPE:       nxt = S_REX;
          OP_BEQ, OP_BNE: nxt = S_BR;
          OP_J:           nxt = S_JMP;
          OP_ADDI:        nxt = S_IEX;
          default:        nxt = S_IF;
        endcase
      end
      S_MADR:  nxt = (bus.opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   nxt = mem_ok ? S_MWB : S_MRD;
      S_MWR:   nxt = mem_ok ? S_IF : S_MWR;
      S_REX:   nxt = S_RWB;
      S_IEX:   nxt = S_IWB;
      default: nxt = S_IF;
    endcase
  end

  mc_ctrl_outdec u_outdec (
    .st            (cur),
    .opcode        (bus.opcode),
    .mem_ok        (mem_ok),
    .rst           (rst),
    .pc_write      (bus.pc_write),
    .pc_write_cond (bus.pc_write_cond),
    .branch_ne     (bus.branch_ne),
    .iord          (bus.iord),
    .mem_read      (bus.mem_read),
    .mem_write     (bus.mem_write),
    .ir_write      (bus.ir_write),
    .memto_reg     (bus.memto_reg),
    .reg_dst       (bus.reg_dst),
    .reg_write     (bus.reg_write),
    .alu_src_a     (bus.alu_src_a),
    .alu_src_b     (bus.alu_src_b),
    .alu_op        (bus.alu_op),
    .pc_source     (bus.pc_source),
    .illegal_op    (bus.illegal_op)
  );

`ifdef MC_CTRL_PERF_CNT_EN
  logic retire;

  // an instruction retires on the final transition back to IF
  always_comb begin
    retire = 1'b0;
    case (cur)
      S_MWB, S_RWB, S_BR, S_JMP, S_IWB: retire = 1'b1;
      S_MWR:                            retire = mem_ok;
      default:                          retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_retired <= 32'd0;
      cyc_cnt      <= 32'd0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (retire) inst_retired <= inst_retired + 32'd1;
    end
  end
`endif

endmodule
